// File: rtl/mem_pkg.sv
// mem_pkg: state and source encodings shared by the memory response demux and the
// address-select logic, so both ends of the unified memory port decode a tag identically.
// Contents: mem_state_t (S_IDLE, S_REQ, S_WAIT), mem_src_t (SRC_INSTR, SRC_DATA).
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mem_state_t;

  // Same encoding as the address-select control: 0 = PCNext fetch, 1 = computed address.
  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_t;

endpackage : mem_pkg

// File: rtl/mem_resp_demux.sv
// Purpose: single-outstanding unified-memory request FSM; steers the returned word to IR or MDR by source tag.
// Latency: response in cycle N -> instr_o/data_o updated and *_valid_o pulsed in N+1; min 3 cycles per transaction.
// Backpressure: req_ready_o only in IDLE; mem_req_valid_o held until mem_req_ready_i; responses outside WAIT dropped.
//
// Ports:
//   clk_i, arst_i (async, active-high)
//   req_valid_i / req_src_i / req_ready_o      core request handshake and source tag
//   mem_req_valid_o / mem_req_ready_i          request to memory
//   mem_resp_valid_i / mem_resp_data_i         returned word
//   instr_o / instr_valid_o                    instruction register and update pulse
//   data_o / data_valid_o                      data register and update pulse
//   busy_o                                     transaction in flight
//   err_timeout_o                              sticky watchdog error
// Build option: define MEM_RESP_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog;
// without it the block waits indefinitely and err_timeout_o is tied low.
module mem_resp_demux
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             req_valid_i,
  input  logic             req_src_i,
  output logic             req_ready_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  input  logic             mem_resp_valid_i,
  input  logic [WIDTH-1:0] mem_resp_data_i,
  output logic [WIDTH-1:0] instr_o,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             err_timeout_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_resp_demux: TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_t state_q, state_d;
  mem_src_t   tag_q;
  logic       accept;     // request taken this cycle (IDLE -> REQ)
  logic       resp_take;  // response consumed this cycle (WAIT -> IDLE)
  logic       expire;     // watchdog fires this cycle
  logic       abort;      // transaction dropped by the watchdog

  // Gated by reset so nothing can be accepted while the block is held in reset.
  assign req_ready_o     = (state_q == S_IDLE) && !arst_i;
  assign mem_req_valid_o = (state_q == S_REQ);
  assign busy_o          = (state_q != S_IDLE);

`ifdef MEM_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             err_q;

  // Counter reads 0 in the first REQ cycle, so the last permitted cycle sees
  // TIMEOUT_CYCLES-1; the increment out of it is the "reached" edge.
  assign expire        = busy_o && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout_o = err_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        wd_cnt_q <= '0;
      end else if (busy_o) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign expire        = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_take = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (expire) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_resp_valid_i) begin
          resp_take = 1'b1;
          state_d   = S_IDLE;
        end else if (expire) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= S_IDLE;
      tag_q         <= SRC_INSTR;
      instr_o       <= '0;
      data_o        <= '0;
      instr_valid_o <= 1'b0;
      data_valid_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_o <= 1'b0;
      data_valid_o  <= 1'b0;
      if (accept) begin
        tag_q <= mem_src_t'(req_src_i);
      end
      if (resp_take) begin
        if (tag_q == SRC_INSTR) begin
          instr_o       <= mem_resp_data_i;
          instr_valid_o <= 1'b1;
        end else begin
          data_o       <= mem_resp_data_i;
          data_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule : mem_resp_demux

// File: tb/tb_mem_resp_demux.sv
// Directed bench for mem_resp_demux: reset, fetch, data with memory stall, spurious
// responses, back-to-back requests, reset mid-transaction, and (with
// MEM_RESP_TIMEOUT_EN) the watchdog at TIMEOUT_CYCLES=8.
module tb_mem_resp_demux;

  localparam int W = 64;
`ifdef MEM_RESP_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic         clk_i = 1'b0;
  logic         arst_i;
  logic         req_valid_i;
  logic         req_src_i;
  logic         req_ready_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic         mem_resp_valid_i;
  logic [W-1:0] mem_resp_data_i;
  logic [W-1:0] instr_o;
  logic         instr_valid_o;
  logic [W-1:0] data_o;
  logic         data_valid_o;
  logic         busy_o;
  logic         err_timeout_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int both   = 0;
  int p0;

  mem_resp_demux #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .req_valid_i      (req_valid_i),
    .req_src_i        (req_src_i),
    .req_ready_o      (req_ready_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .instr_o          (instr_o),
    .instr_valid_o    (instr_valid_o),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .busy_o           (busy_o),
    .err_timeout_o    (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clk_i) begin
    if (!arst_i) begin
      if (instr_valid_o) pulses++;
      if (data_valid_o)  pulses++;
      if (instr_valid_o && data_valid_o) both++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    arst_i           = 1'b1;
    req_valid_i      = 1'b0;
    req_src_i        = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;

    // 1 Reset
    #12;
    chk("rst_instr",   instr_o, 64'h0);
    chk("rst_data",    data_o, 64'h0);
    chk("rst_ivld",    {63'h0, instr_valid_o}, 64'h0);
    chk("rst_dvld",    {63'h0, data_valid_o}, 64'h0);
    chk("rst_ready",   {63'h0, req_ready_o}, 64'h0);
    chk("rst_memvld",  {63'h0, mem_req_valid_o}, 64'h0);
    chk("rst_busy",    {63'h0, busy_o}, 64'h0);
    chk("rst_err",     {63'h0, err_timeout_o}, 64'h0);
    arst_i = 1'b0;
    cyc();
    chk("rel_ready",   {63'h0, req_ready_o}, 64'h1);

    // 2 Fetch
    req_valid_i = 1'b1; req_src_i = 1'b0;
    cyc();                                            // cycle 1: REQ
    chk("f_memvld",    {63'h0, mem_req_valid_o}, 64'h1);
    chk("f_ready_lo",  {63'h0, req_ready_o}, 64'h0);
    req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    cyc();                                            // cycle 2: WAIT
    chk("f_memvld_lo", {63'h0, mem_req_valid_o}, 64'h0);
    mem_req_ready_i = 1'b0;
    cyc();                                            // cycle 3: response
    chk("f_ivld_c3",   {63'h0, instr_valid_o}, 64'h0);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h0000_0000_0010_0093;
    cyc();                                            // cycle 4
    mem_resp_valid_i = 1'b0;
    chk("f_instr",     instr_o, 64'h0000_0000_0010_0093);
    chk("f_ivld_c4",   {63'h0, instr_valid_o}, 64'h1);
    chk("f_dvld_c4",   {63'h0, data_valid_o}, 64'h0);
    chk("f_data",      data_o, 64'h0);
    chk("f_ready",     {63'h0, req_ready_o}, 64'h1);
    cyc();
    chk("f_ivld_c5",   {63'h0, instr_valid_o}, 64'h0);

    // 3 Data with memory stalled 5 cycles
    req_valid_i = 1'b1; req_src_i = 1'b1;
    cyc();
    req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("d_memvld_%0d", i), {63'h0, mem_req_valid_o}, 64'h1);
      cyc();
    end
    chk("d_memvld_5",  {63'h0, mem_req_valid_o}, 64'h1);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    chk("d_wait",      {63'h0, mem_req_valid_o}, 64'h0);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'hDEAD_BEEF_CAFE_F00D;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("d_data",      data_o, 64'hDEAD_BEEF_CAFE_F00D);
    chk("d_dvld",      {63'h0, data_valid_o}, 64'h1);
    chk("d_ivld",      {63'h0, instr_valid_o}, 64'h0);
    chk("d_instr",     instr_o, 64'h0000_0000_0010_0093);
    cyc();
    chk("d_dvld_off",  {63'h0, data_valid_o}, 64'h0);

    // 4 Spurious responses in IDLE and REQ
    p0 = pulses;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    chk("s_idle_instr", instr_o, 64'h0000_0000_0010_0093);
    chk("s_idle_data",  data_o, 64'hDEAD_BEEF_CAFE_F00D);
    mem_resp_valid_i = 1'b0;
    req_valid_i = 1'b1; req_src_i = 1'b0;
    cyc();                                            // REQ, memory not ready
    req_valid_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h5555_5555_5555_5555;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("s_req_hold",   {63'h0, mem_req_valid_o}, 64'h1);
    chk("s_req_instr",  instr_o, 64'h0000_0000_0010_0093);
    chk("s_pulses",     64'(pulses - p0), 64'h0);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h0000_0000_0000_1111;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("s_fin_instr",  instr_o, 64'h0000_0000_0000_1111);
    chk("s_fin_data",   data_o, 64'hDEAD_BEEF_CAFE_F00D);
    cyc();

    // 5 Back-to-back fetch then data, req_valid_i held high
    p0 = pulses;
    req_valid_i = 1'b1; req_src_i = 1'b0; mem_req_ready_i = 1'b1;
    cyc();                                            // REQ
    cyc();                                            // WAIT
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h0000_0000_00A0_0513;
    cyc();                                            // IDLE, fetch done
    mem_resp_valid_i = 1'b0;
    chk("b_ivld",      {63'h0, instr_valid_o}, 64'h1);
    chk("b_ready",     {63'h0, req_ready_o}, 64'h1);
    chk("b_instr",     instr_o, 64'h0000_0000_00A0_0513);
    req_src_i = 1'b1;
    cyc();                                            // second request accepted
    chk("b_acc",       {63'h0, mem_req_valid_o}, 64'h1);
    req_valid_i = 1'b0;
    cyc();                                            // WAIT
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h0123_4567_89AB_CDEF;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("b_dvld",      {63'h0, data_valid_o}, 64'h1);
    chk("b_data",      data_o, 64'h0123_4567_89AB_CDEF);
    chk("b_instr2",    instr_o, 64'h0000_0000_00A0_0513);
    cyc();
    cyc();
    chk("b_pulses",    64'(pulses - p0), 64'h2);
    chk("both_never",  64'(both), 64'h0);
    chk("err_default", {63'h0, err_timeout_o}, 64'h0);

    // 6 Reset in the middle of a data transaction
    p0 = pulses;
    req_valid_i = 1'b1; req_src_i = 1'b1;
    cyc();
    req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    cyc();                                            // WAIT
    mem_req_ready_i = 1'b0;
    #3 arst_i = 1'b1;
    #1;
    chk("mr_instr",    instr_o, 64'h0);
    chk("mr_data",     data_o, 64'h0);
    chk("mr_busy",     {63'h0, busy_o}, 64'h0);
    chk("mr_ready",    {63'h0, req_ready_o}, 64'h0);
    chk("mr_memvld",   {63'h0, mem_req_valid_o}, 64'h0);
    #2 arst_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h7777_7777_7777_7777;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("mr_dvld",     {63'h0, data_valid_o}, 64'h0);
    chk("mr_data2",    data_o, 64'h0);
    chk("mr_ready2",   {63'h0, req_ready_o}, 64'h1);
    cyc();
    chk("mr_pulses",   64'(pulses - p0), 64'h0);

`ifdef MEM_RESP_TIMEOUT_EN
    // 7 Watchdog: 8 cycles in REQ without response
    p0 = pulses;
    req_valid_i = 1'b1; req_src_i = 1'b0;
    cyc();                                            // REQ cycle 1
    req_valid_i = 1'b0;
    for (int i = 1; i < TO; i++) cyc();               // REQ cycle 8
    chk("t_busy_8",    {63'h0, busy_o}, 64'h1);
    chk("t_err_8",     {63'h0, err_timeout_o}, 64'h0);
    cyc();
    chk("t_err",       {63'h0, err_timeout_o}, 64'h1);
    chk("t_idle",      {63'h0, req_ready_o}, 64'h1);
    chk("t_pulses",    64'(pulses - p0), 64'h0);
    req_valid_i = 1'b1; req_src_i = 1'b0; mem_req_ready_i = 1'b1;
    cyc();
    req_valid_i = 1'b0;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'h0000_0000_0000_2222;
    cyc();
    mem_resp_valid_i = 1'b0;
    chk("t_instr",     instr_o, 64'h0000_0000_0000_2222);
    chk("t_sticky",    {63'h0, err_timeout_o}, 64'h1);
    arst_i = 1'b1;
    #1;
    chk("t_clr",       {63'h0, err_timeout_o}, 64'h0);
    arst_i = 1'b0;
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_resp_demux
